id_scoreboard_ctrl: RTL
=======================

Name: id_scoreboard_ctrl

Overview:
Issue/interlock controller for the decode stage. It keeps a per-register scoreboard of in-flight writes to the register file. When an instruction in ID reads a register with a pending write, or hits a structural conflict on the long-latency (mul/div) unit, it holds ID and injects a bubble into ID/EX. Sits beside the decode block: it consumes the decoded source/dest fields and the WB write port, and drives the IF/ID hold and the ID/EX valid.

Parameters:
ADDR_W, 5, register address width
NREGS, 32, number of architectural registers (register 0 hard-wired zero)
CNT_W, 2, per-register pending-write counter width (max 3 in flight)
LONG_LAT, 8, long-latency unit occupancy in cycles (≥2)

Ports:
p_clk  in  1  clock
p_reset  in  1  reset, synchronous, active-high
p_ID_Valid  in  1  instruction in ID is valid
p_ID_Flush  in  1  squash instruction in ID (branch redirect)
p_ID_SrcA  in  ADDR_W  rs field
p_ID_SrcA_Used  in  1  rs is read
p_ID_SrcB  in  ADDR_W  rt field
p_ID_SrcB_Used  in  1  rt is read
p_ID_Dest  in  ADDR_W  selected destination (rt or rd)
p_ID_Dest_We  in  1  instruction writes p_ID_Dest
p_ID_IsLong  in  1  instruction uses long-latency unit
p_WB_Addr  in  ADDR_W  WB write address
p_WB_WE  in  1  WB write enable
p_Stall  out  1  hold PC and IF/ID
p_Issue  out  1  ID/EX valid (0 = bubble)
p_Long_Busy  out  1  long unit occupied
p_Long_Done  out  1  one-cycle pulse, final busy cycle
p_Pending  out  NREGS  bit i = counter i nonzero
p_Err  out  1  sticky: WB to register with zero count

Behaviour:
- Reset (sync, active-high): all counters 0; long FSM IDLE, down-counter 0. Outputs: p_Long_Busy=0, p_Long_Done=0, p_Pending=0, p_Err=0. p_Stall/p_Issue follow their combinational equations on state and inputs; with p_ID_Valid=0 both are 0. Reset overrides all same-cycle events, including mid-long-op.
- Hazard terms:
  - rawA = SrcA_Used & SrcA≠0 & cnt[SrcA]≠0
  - rawB likewise for SrcB.
  - No WB bypass: a WB write to the same register in the same cycle does not clear the hazard this cycle.
  - sat = Dest_We & Dest≠0 & cnt[Dest]==max.
  - struct = IsLong & Long_Busy & ~Long_Done.
- p_Stall = ID_Valid & ~ID_Flush & (rawA|rawB|sat|struct). Combinational.
- p_Issue = ID_Valid & ~ID_Flush & ~p_Stall. Combinational.
- Counter update, registered:
  - inc when Issue & Dest_We & Dest≠0.
  - dec[WB_Addr] when WB_WE & WB_Addr≠0.
  - Same register inc and dec in one cycle: count unchanged.
  - Dec at 0: count stays 0, p_Err sets and remains set until reset.
  - Register 0 is never counted.
- Long FSM:
  - IDLE→BUSY on Issue & IsLong; load counter LONG_LAT-1.
  - BUSY: decrement each cycle; p_Long_Done=1 when counter==0.
  - Counter==0 with Issue & IsLong: reload LONG_LAT-1, stay BUSY (back-to-back).
  - Counter==0 otherwise: →IDLE.
  - p_Long_Busy = (state==BUSY).
- Flush: squashed instruction never issues, never increments. In-flight writes already counted still retire via WB.
- p_Pending is a registered view (reduction of counters); it reflects updates one cycle after the causing edge.

Decomposition:
- Shared package/header: ADDR_W, NREGS, CNT_W, LONG_LAT defaults; FSM state encodings (ST_IDLE, ST_BUSY).
- One natural sub-module: sb_counter_bank, NREGS saturating up/down counters with inc/dec address ports and a nonzero bitmap.
- FSM and hazard logic stay in the top.

Test Plan:
1. Issue write to r5, next cycle instruction reads r5 → p_Stall=1, p_Issue=0 until the cycle after WB_WE with WB_Addr=5; then p_Issue=1, p_Pending[5]=0.
2. Read/write r0 with Dest_We=1 → never stalls; p_Pending stays 0; WB to r0 does not set p_Err.
3. Three writes to r7 issue, fourth write to r7 → stalled (sat); one WB to r7 → fourth issues; count returns to 3.
4. Long op issues at cycle t, second long op presented at t+1 → stalled; issues at t+LONG_LAT with p_Long_Done=1 that cycle; p_Long_Busy never drops.
5. Same cycle: Issue with Dest=9 and WB_WE to r9, count 1 → count stays 1. WB to r12 with count 0 → p_Err=1, held until p_reset.
6. p_reset asserted during BUSY with pending counts → next cycle p_Long_Busy=0, p_Pending=0, p_Err=0. p_ID_Flush with a hazardous instruction → p_Stall=0, p_Issue=0.

Source files
------------

// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared defaults and state encodings for the decode-stage scoreboard/interlock.
package id_scoreboard_ctrl_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NREGS    = 32;
    localparam int DEF_CNT_W    = 2;
    localparam int DEF_LONG_LAT = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } long_state_e;

endpackage

// File: rtl/id_scoreboard_ctrl_if.sv
// Decode-side and writeback-side signals seen by the scoreboard controller.
interface id_scoreboard_ctrl_if
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) ();

    logic              p_ID_Valid;
    logic              p_ID_Flush;
    logic [ADDR_W-1:0] p_ID_SrcA;
    logic              p_ID_SrcA_Used;
    logic [ADDR_W-1:0] p_ID_SrcB;
    logic              p_ID_SrcB_Used;
    logic [ADDR_W-1:0] p_ID_Dest;
    logic              p_ID_Dest_We;
    logic              p_ID_IsLong;
    logic [ADDR_W-1:0] p_WB_Addr;
    logic              p_WB_WE;

    logic              p_Stall;
    logic              p_Issue;
    logic              p_Long_Busy;
    logic              p_Long_Done;
    logic [NREGS-1:0]  p_Pending;
    logic              p_Err;

    // Decode/writeback side: drives instruction fields, observes interlock.
    modport master (
        output p_ID_Valid, p_ID_Flush, p_ID_SrcA, p_ID_SrcA_Used,
               p_ID_SrcB, p_ID_SrcB_Used, p_ID_Dest, p_ID_Dest_We,
               p_ID_IsLong, p_WB_Addr, p_WB_WE,
        input  p_Stall, p_Issue, p_Long_Busy, p_Long_Done, p_Pending, p_Err
    );

    // Scoreboard controller side.
    modport slave (
        input  p_ID_Valid, p_ID_Flush, p_ID_SrcA, p_ID_SrcA_Used,
               p_ID_SrcB, p_ID_SrcB_Used, p_ID_Dest, p_ID_Dest_We,
               p_ID_IsLong, p_WB_Addr, p_WB_WE,
        output p_Stall, p_Issue, p_Long_Busy, p_Long_Done, p_Pending, p_Err
    );

endinterface

// File: rtl/id_scoreboard_ctrl_sb_counter_bank.sv
// Bank of per-register saturating pending-write counters. Register 0 is never
// counted; a decrement of a zero counter raises a sticky error flag.
module sb_counter_bank
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              dec_en,
    input  logic [ADDR_W-1:0] dec_addr,
    output logic [NREGS-1:0]  nonzero,
    output logic [NREGS-1:0]  full,
    output logic              underflow_err
);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;

    // Decode increment/decrement addresses into one-hot vectors, skipping r0.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            inc_vec[i] = inc_en && (inc_addr == ADDR_W'(i));
            dec_vec[i] = dec_en && (dec_addr == ADDR_W'(i));
        end
    end

    // Counter update; simultaneous inc and dec of one register cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (inc_vec[i] && !dec_vec[i] && !(&cnt_q[i]))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && (|cnt_q[i]))
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Sticky flag for a writeback to a register with no counted write.
    always_ff @(posedge clk) begin
        if (reset)
            underflow_err <= 1'b0;
        else if (dec_en && (dec_addr != '0) && !nonzero[dec_addr])
            underflow_err <= 1'b1;
    end

    // Nonzero and saturated bitmaps straight off the counter registers.
    always_comb begin
        nonzero = '0;
        full    = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            nonzero[i] = |cnt_q[i];
            full[i]    = &cnt_q[i];
        end
    end

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage issue/interlock controller: RAW and saturation hazards against
// the register scoreboard, plus structural interlock on the long-latency unit.
module id_scoreboard_ctrl
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LONG_LAT = DEF_LONG_LAT
) (
    input  logic                 p_clk,
    input  logic                 p_reset,
    id_scoreboard_ctrl_if.slave  bus
);

    localparam int LCNT_W = $clog2(LONG_LAT);
    localparam logic [LCNT_W-1:0] LONG_LOAD = LCNT_W'(LONG_LAT - 1);

    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  full;
    logic              err;
    logic              raw_a;
    logic              raw_b;
    logic              sat;
    logic              strct;
    logic              stall;
    logic              issue;
    logic              inc_en;
    logic              dec_en;

    long_state_e       state_q;
    long_state_e       state_d;
    logic [LCNT_W-1:0] lcnt_q;
    logic [LCNT_W-1:0] lcnt_d;
    logic              long_busy;
    logic              long_done;

    sb_counter_bank #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk           (p_clk),
        .reset         (p_reset),
        .inc_en        (inc_en),
        .inc_addr      (bus.p_ID_Dest),
        .dec_en        (dec_en),
        .dec_addr      (bus.p_WB_Addr),
        .nonzero       (pending),
        .full          (full),
        .underflow_err (err)
    );

    // Hazard detection and issue decision; no writeback bypass.
    always_comb begin
        raw_a  = bus.p_ID_SrcA_Used && (bus.p_ID_SrcA != '0) && pending[bus.p_ID_SrcA];
        raw_b  = bus.p_ID_SrcB_Used && (bus.p_ID_SrcB != '0) && pending[bus.p_ID_SrcB];
        sat    = bus.p_ID_Dest_We && (bus.p_ID_Dest != '0) && full[bus.p_ID_Dest];
        strct  = bus.p_ID_IsLong && long_busy && !long_done;
        stall  = bus.p_ID_Valid && !bus.p_ID_Flush && (raw_a || raw_b || sat || strct);
        issue  = bus.p_ID_Valid && !bus.p_ID_Flush && !stall;
        inc_en = issue && bus.p_ID_Dest_We && (bus.p_ID_Dest != '0);
        dec_en = bus.p_WB_WE && (bus.p_WB_Addr != '0);
    end

    // Long-unit state and occupancy down-counter.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Long-unit next state; a new long op may start on the final busy cycle.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (issue && bus.p_ID_IsLong) begin
                    state_d = ST_BUSY;
                    lcnt_d  = LONG_LOAD;
                end
            end
            ST_BUSY: begin
                if (lcnt_q != '0)
                    lcnt_d = lcnt_q - LCNT_W'(1);
                else if (issue && bus.p_ID_IsLong)
                    lcnt_d = LONG_LOAD;
                else
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Long-unit status outputs decoded from state.
    always_comb begin
        long_busy = (state_q == ST_BUSY);
        long_done = long_busy && (lcnt_q == '0);
    end

    // Drive the interface outputs.
    always_comb begin
        bus.p_Stall     = stall;
        bus.p_Issue     = issue;
        bus.p_Long_Busy = long_busy;
        bus.p_Long_Done = long_done;
        bus.p_Pending   = pending;
        bus.p_Err       = err;
    end

endmodule
